// File: rtl/espiro_pkg.sv
// Shared constants and FSM encoding for the ADC sampler.
// ADC_AVG4_EN adds the GAP state used between averaged conversions.
package espiro_pkg;
  localparam int SPI_BITS = 15;
  localparam int SPI_SKIP = 3;
  localparam int AVG_N    = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
`ifdef ADC_AVG4_EN
    , GAP    = 3'd5
`endif
  } state_e;
endpackage

// File: rtl/adc_sampler_spi_half_tick.sv
// SCLK half-period counter: counts 0..CLK_DIV-1 while enabled and wraps.
// tc_o marks the last cycle of each half-period.
module spi_half_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic iClk,
  input  logic iReset,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iReset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/adc_sampler.sv
// SPI ADC sampler: one tick -> CS frame of 15 SCLK periods, last 12 bits kept.
// Define ADC_AVG4_EN to run four conversions per tick and output their mean.
module adc_sampler import espiro_pkg::*; #(
  parameter int CLK_DIV = 25,
  parameter int DATA_W  = 12
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iTick,
  input  logic              iClrOvr,
  input  logic              iMiso,
  output logic              oSclk,
  output logic              oCs_n,
  output logic [DATA_W-1:0] ovSample,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOverrun
);
  state_e            state_q, state_d;
  logic [4:0]        half_q, half_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              ovr_q, ovr_d;
  logic              tc, cnt_load;
`ifdef ADC_AVG4_EN
  localparam int SW = DATA_W + 2;
  logic [1:0]        conv_q, conv_d;
  logic [SW-1:0]     sum_q, sum_d;
`endif

  // Counter is held at zero outside the active frame.
  assign cnt_load = (state_q == IDLE) || (state_q == DONE);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half (
    .iClk   (iClk),
    .iReset (iReset),
    .load_i (cnt_load),
    .en_i   (!cnt_load),
    .tc_o   (tc)
  );

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    ovr_d    = iClrOvr ? 1'b0 : ovr_q;
`ifdef ADC_AVG4_EN
    conv_d   = conv_q;
    sum_d    = sum_q;
`endif
    if (iTick && state_q != IDLE) ovr_d = 1'b1;
    case (state_q)
      IDLE: if (iTick) begin
        state_d = CS_SETUP;
`ifdef ADC_AVG4_EN
        conv_d  = '0;
        sum_d   = '0;
`endif
      end
      CS_SETUP: if (tc) begin
        state_d = SHIFT;
        half_d  = '0;
      end
      SHIFT: if (tc) begin
        // Even half ending = SCLK rising edge; leading rises are dummy bits.
        if (!half_q[0] && half_q[4:1] >= 4'(SPI_SKIP))
          shift_d = {shift_q[DATA_W-2:0], iMiso};
        if (half_q == 5'(2*SPI_BITS - 1)) begin
          state_d = CS_HOLD;
          half_d  = '0;
        end else begin
          half_d  = half_q + 5'd1;
        end
      end
      CS_HOLD: if (tc) begin
`ifdef ADC_AVG4_EN
        sum_d = sum_q + SW'(shift_q);
        if (conv_q == 2'(AVG_N - 1)) begin
          state_d  = DONE;
          sample_d = sum_d[SW-1:2];
        end else begin
          state_d  = GAP;
          conv_d   = conv_q + 2'd1;
        end
`else
        state_d  = DONE;
        sample_d = shift_q;
`endif
      end
`ifdef ADC_AVG4_EN
      GAP: if (tc) state_d = CS_SETUP;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= IDLE;
      half_q   <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      ovr_q    <= 1'b0;
`ifdef ADC_AVG4_EN
      conv_q   <= '0;
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      ovr_q    <= ovr_d;
`ifdef ADC_AVG4_EN
      conv_q   <= conv_d;
      sum_q    <= sum_d;
`endif
    end
  end

  assign oCs_n    = !(state_q == CS_SETUP || state_q == SHIFT || state_q == CS_HOLD);
  assign oSclk    = (state_q == SHIFT) && half_q[0];
  assign oValid   = (state_q == DONE);
  assign oBusy    = (state_q != IDLE);
  assign oOverrun = ovr_q;
  assign ovSample = sample_q;
endmodule
